// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready stream handshake.
// One WIDTH/STAGES-bit slice is resolved per stage; slice carries are registered.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int S = WIDTH / STAGES;

    generate
        if (STAGES < 1 || GROUP < 2 || (WIDTH % (STAGES * GROUP)) != 0) begin : g_bad_cfg
            $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES*GROUP");
        end
    endgenerate

    function automatic int calc_levels();
        int n;
        int l;
        n = 1;
        l = 0;
        while (n < S) begin
            n = n * GROUP;
            l++;
        end
        return (l < 1) ? 1 : l;
    endfunction

    localparam int LV = calc_levels();

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             z;
    } stage_t;

    // Node i of level l spans GROUP^l bits; P/G are folded upward, carries pushed down.
    function automatic logic [S:0] cla_slice(
        input logic [S-1:0] x,
        input logic [S-1:0] y,
        input logic         ci
    );
        logic [S-1:0] p [LV+1];
        logic [S-1:0] g [LV+1];
        logic [S-1:0] c [LV+1];
        logic         pr;
        logic         gr;
        logic         cr;
        int           idx;
        p[0] = x ^ y;
        g[0] = x & y;
        for (int l = 1; l <= LV; l++) begin
            p[l] = '0;
            g[l] = '0;
            for (int i = 0; i < S; i++) begin
                pr = 1'b1;
                gr = 1'b0;
                for (int j = 0; j < GROUP; j++) begin
                    idx = i * GROUP + j;
                    if (idx < S) begin
                        gr = g[l-1][idx] | (p[l-1][idx] & gr);
                        pr = pr & p[l-1][idx];
                    end
                end
                p[l][i] = pr;
                g[l][i] = gr;
            end
        end
        for (int l = 0; l <= LV; l++) begin
            c[l] = '0;
        end
        c[LV][0] = ci;
        for (int l = LV; l >= 1; l--) begin
            for (int i = 0; i < S; i++) begin
                cr = c[l][i];
                for (int j = 0; j < GROUP; j++) begin
                    idx = i * GROUP + j;
                    if (idx < S) begin
                        c[l-1][idx] = cr;
                        cr = g[l-1][idx] | (p[l-1][idx] & cr);
                    end
                end
            end
        end
        return {g[LV][0] | (p[LV][0] & ci), p[0] ^ c[0]};
    endfunction

    stage_t st_q [STAGES+1];
    stage_t st_d [STAGES+1];
    logic   adv;

    assign adv      = !st_q[STAGES].v || out_ready;
    assign in_ready = adv;

    always_comb begin
        logic [S:0] res;
        res     = '0;
        st_d[0] = '{
            v: in_valid,
            a: a,
            b: sub ? ~b : b,
            s: '0,
            c: sub ^ cin,
            z: 1'b1
        };
        for (int k = 0; k < STAGES; k++) begin
            res = cla_slice(st_q[k].a[k*S +: S], st_q[k].b[k*S +: S], st_q[k].c);
            st_d[k+1]            = st_q[k];
            st_d[k+1].s[k*S +: S] = res[S-1:0];
            st_d[k+1].c          = res[S];
            st_d[k+1].z          = st_q[k].z & (res[S-1:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k <= STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign out_valid = st_q[STAGES].v;
    assign sum       = st_q[STAGES].s;
    assign cout      = st_q[STAGES].c;
    assign zero      = st_q[STAGES].z;
    assign negative  = st_q[STAGES].s[WIDTH-1];
    assign overflow  = (st_q[STAGES].a[WIDTH-1] == st_q[STAGES].b[WIDTH-1])
                    && (st_q[STAGES].s[WIDTH-1] != st_q[STAGES].a[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: three configurations, directed table,
// backpressure, mid-flight reset and randomized streams against a reference model.
module tb_pipelined_cla_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid_s  [3];
    logic        out_ready_s [3];
    logic        cin_s       [3];
    logic        sub_s       [3];
    logic [63:0] a_s         [3];
    logic [63:0] b_s         [3];
    logic        in_ready_s  [3];
    logic        out_valid_s [3];
    logic        cout_s      [3];
    logic        ovf_s       [3];
    logic        zero_s      [3];
    logic        neg_s       [3];
    logic [63:0] sum_s       [3];
    logic [31:0] sum1;
    logic [15:0] sum2;

    assign sum_s[1] = {32'd0, sum1};
    assign sum_s[2] = {48'd0, sum2};

    pipelined_cla_addsub #(.WIDTH(64), .STAGES(4), .GROUP(4)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .sum(sum_s[0]), .cout(cout_s[0]), .overflow(ovf_s[0]),
        .zero(zero_s[0]), .negative(neg_s[0])
    );

    pipelined_cla_addsub #(.WIDTH(32), .STAGES(2), .GROUP(4)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1][31:0]), .b(b_s[1][31:0]), .cin(cin_s[1]), .sub(sub_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .sum(sum1), .cout(cout_s[1]), .overflow(ovf_s[1]),
        .zero(zero_s[1]), .negative(neg_s[1])
    );

    pipelined_cla_addsub #(.WIDTH(16), .STAGES(1), .GROUP(4)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2][15:0]), .b(b_s[2][15:0]), .cin(cin_s[2]), .sub(sub_s[2]),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .sum(sum2), .cout(cout_s[2]), .overflow(ovf_s[2]),
        .zero(zero_s[2]), .negative(neg_s[2])
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        res_t        r;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [67:0] pk(input res_t r);
        return {r.s, r.c, r.o, r.z, r.n};
    endfunction

    function automatic logic [67:0] outs(input int d);
        return {sum_s[d], cout_s[d], ovf_s[d], zero_s[d], neg_s[d]};
    endfunction

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] one;
        one = 64'd1;
        return (w == 64) ? '1 : ((one << w) - 64'd1);
    endfunction

    function automatic logic [65:0] sext(input logic [63:0] v, input int w);
        logic [65:0] r;
        r = {2'b00, v};
        if (v[w-1]) begin
            for (int i = w; i < 66; i++) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Plain-integer reference: true sum width w+1, signed overflow as range escape.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input int w);
        res_t        r;
        logic [63:0] m;
        logic [63:0] be;
        logic        ce;
        logic [64:0] full;
        m    = wmask(w);
        be   = sub ? (~b & m) : (b & m);
        ce   = sub ? ~cin : cin;
        full = {1'b0, a & m} + {1'b0, be} + {64'd0, ce};
        r.s  = full[63:0] & m;
        r.c  = full[w];
        r.o  = (sext(a & m, w) + sext(be, w) + {65'd0, ce}) != sext(r.s, w);
        r.z  = (r.s == 64'd0);
        r.n  = r.s[w-1];
        return r;
    endfunction

    task automatic one_beat(input int d, input int st, input vec_t v);
        out_ready_s[d] = 1'b1;
        in_valid_s[d]  = 1'b1;
        a_s[d]   = v.a;
        b_s[d]   = v.b;
        cin_s[d] = v.cin;
        sub_s[d] = v.sub;
        @(negedge clk);
        chk("beat_in_ready", in_ready_s[d], 1);
        @(posedge clk);
        #1 in_valid_s[d] = 1'b0;
        repeat (st - 1) @(posedge clk);
        @(negedge clk);
        chk("beat_early_valid", out_valid_s[d], 0);
        @(posedge clk);
        @(negedge clk);
        chk("beat_valid", out_valid_s[d], 1);
        chk("beat_result", outs(d), pk(v.r));
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int d, input int w, input int n, input bit scripted);
        res_t        q[$];
        res_t        e;
        logic [67:0] held;
        logic [63:0] m;
        bit          hold_prev;
        int          sent;
        int          got;
        int          cyc;
        m         = wmask(w);
        hold_prev = 0;
        held      = '0;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        while (got < n && cyc < 40 * n + 200) begin
            if (scripted) out_ready_s[d] = !(cyc >= 6 && cyc <= 9);
            else out_ready_s[d] = ($urandom_range(0, 3) != 0);
            if (sent < n && (scripted || $urandom_range(0, 3) != 0)) begin
                in_valid_s[d] = 1'b1;
                a_s[d] = {$urandom, $urandom} & m;
                b_s[d] = {$urandom, $urandom} & m;
                if ($urandom_range(0, 7) == 0) a_s[d] = m;
                if ($urandom_range(0, 7) == 0) b_s[d] = $urandom_range(0, 1) ? m : 64'd0;
                cin_s[d] = 1'($urandom_range(0, 1));
                sub_s[d] = 1'($urandom_range(0, 1));
            end else begin
                in_valid_s[d] = 1'b0;
            end
            @(negedge clk);
            if (hold_prev) chk("hold_stable", {out_valid_s[d], outs(d)}, {1'b1, held});
            chk("in_ready", in_ready_s[d], !out_valid_s[d] || out_ready_s[d]);
            if (scripted && cyc >= 6 && cyc <= 9) chk("stall_in_ready", in_ready_s[d], 0);
            if (out_valid_s[d] && out_ready_s[d]) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("stream_result", outs(d), pk(e));
                end
                got++;
            end
            hold_prev = out_valid_s[d] && !out_ready_s[d];
            held      = outs(d);
            if (in_valid_s[d] && in_ready_s[d]) begin
                q.push_back(model(a_s[d], b_s[d], cin_s[d], sub_s[d], w));
                sent++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        chk("stream_count", got, n);
        chk("stream_drained", q.size(), 0);
        in_valid_s[d]  = 1'b0;
        out_ready_s[d] = 1'b1;
    endtask

    task automatic lat(input int d, input int st);
        int n;
        out_ready_s[d] = 1'b1;
        in_valid_s[d]  = 1'b1;
        a_s[d]   = 64'd1;
        b_s[d]   = 64'd2;
        cin_s[d] = 1'b0;
        sub_s[d] = 1'b0;
        @(posedge clk);
        #1 in_valid_s[d] = 1'b0;
        n = 0;
        while (!out_valid_s[d] && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", n, st);
        chk("latency_sum", sum_s[d], 3);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{64'h5, 64'h3, 0, 0, '{64'h8, 0, 0, 0, 0}};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, '{64'h0, 1, 0, 1, 0}};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'h1, 0, 1,
                   '{64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0}};
        tbl[3] = '{64'h3, 64'h5, 0, 1, '{64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1}};
        tbl[4] = '{64'd10, 64'd3, 1, 1, '{64'd6, 1, 0, 0, 0}};
        tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0,
                   '{64'h8000_0000_0000_0000, 0, 1, 0, 1}};
        tbl[6] = '{64'h0, 64'h0, 0, 1, '{64'h0, 1, 0, 1, 0}};
        tbl[7] = '{64'h0000_0000_0000_FFFF, 64'h1, 0, 0, '{64'h1_0000, 0, 0, 0, 0}};

        for (int d = 0; d < 3; d++) begin
            in_valid_s[d]  = 1'b0;
            out_ready_s[d] = 1'b1;
            a_s[d]   = '0;
            b_s[d]   = '0;
            cin_s[d] = 1'b0;
            sub_s[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", out_valid_s[d], 0);
            chk("reset_outs", outs(d), 0);
            chk("reset_in_ready", in_ready_s[d], 1);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) one_beat(0, 4, tbl[i]);

        stream(0, 64, 10, 1);

        out_ready_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_s[0] = 1'b1;
            a_s[0] = 64'(i + 1);
            b_s[0] = 64'd7;
            sub_s[0] = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid_s[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_valid", out_valid_s[0], 0);
            if (i == 0) chk("flush_in_ready", in_ready_s[0], 1);
            @(posedge clk);
            #1;
        end

        stream(0, 64, 2000, 0);
        lat(0, 4);
        lat(1, 2);
        stream(1, 32, 10000, 0);
        lat(2, 1);
        stream(2, 16, 10000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
